spi_rx_deser: RTL and testbench

Receive-side deserializer for the three-wire strobe/clock/data SPI link driven by the FIFO-fed SPI transmitter. It oversamples `spi_stb`/`spi_clk`/`spi_dio` in the system clock domain and rebuilds bytes LSB-first. Completed bytes are presented on a valid/ready output with a first-byte-of-frame marker. It sits directly downstream of the transmitter: as a loopback checker in bench and on-board diagnostics, and as the front end of any display-emulation logic.

---
 rtl/spi_rx_pkg.sv | 13 +
 rtl/sync_ff.sv | 24 ++
 rtl/spi_rx_deser.sv | 149 ++++++++++++++
 tb/tb_spi_rx_deser.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_rx_pkg.sv
// Shared types and default constants for the SPI receive deserializer.
package spi_rx_pkg;

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    RECV
  } state_t;

  localparam int DEF_DATA_W      = 8;
  localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop single-bit synchronizer with a configurable depth and reset level.
module sync_ff #(
  parameter int   DEPTH   = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] ff_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ff_q <= {DEPTH{RST_VAL}};
    end else begin
      ff_q <= {ff_q[DEPTH-2:0], d};
    end
  end

  assign q = ff_q[DEPTH-1];

endmodule

// File: rtl/spi_rx_deser.sv
// Oversampling SPI receiver: rebuilds LSB-first words from stb/clk/dio and
// presents them on a valid/ready port with a first-of-frame marker.
module spi_rx_deser
  import spi_rx_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DATA_W      = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_stb,
  input  logic              spi_clk,
  input  logic              spi_dio,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_first,
  output logic              overrun,
  input  logic              overrun_clr,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam int SET_W = $clog2(SYNC_STAGES + 1);

  logic stb_s, clk_s, dio_s;
  logic stb_q, clk_q;

  sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_stb (
    .clk(clk), .rst(rst), .d(spi_stb), .q(stb_s)
  );
  sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_clk (
    .clk(clk), .rst(rst), .d(spi_clk), .q(clk_s)
  );
  sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_dio (
    .clk(clk), .rst(rst), .d(spi_dio), .q(dio_s)
  );

  logic clk_rise, stb_fall, stb_rise;
  assign clk_rise = clk_s & ~clk_q;
  assign stb_fall = ~stb_s & stb_q;
  assign stb_rise = stb_s & ~stb_q;

  // The synchronizers reset to idle levels, so WAIT_IDLE must not trust
  // stb_s until the real pin value has flushed through all stages.
  logic [SET_W-1:0] settle_q;
  logic             settled;
  assign settled = (settle_q == SET_W'(SYNC_STAGES));

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q;
  logic [DATA_W-2:0] shift_q;
  logic             first_q;
  logic             start, take, done, err;

  always_comb begin
    // NOTE: every signal written here is given a default first, so no path leaves it unassigned and no latch is inferred.
    state_d = state_q;
    start   = 1'b0;
    take    = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    unique case (state_q)
      WAIT_IDLE: if (settled && stb_s) state_d = IDLE;
      IDLE: begin
        if (stb_fall) begin
          state_d = RECV;
          start   = 1'b1;
        end
      end
      RECV: begin
        if (clk_rise) begin
          take = 1'b1;
          done = (count_q == CNT_W'(DATA_W - 1));
        end
        // A clock edge coinciding with the strobe rise is consumed first.
        if (stb_rise) begin
          state_d = IDLE;
          err     = clk_rise ? !done : (count_q != '0);
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (!rst) begin
      state_q  <= WAIT_IDLE;
      stb_q    <= 1'b1;
      clk_q    <= 1'b1;
      settle_q <= '0;
    end else begin
      state_q <= state_d;
      stb_q   <= stb_s;
      clk_q   <= clk_s;
      if (!settled) settle_q <= settle_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q   <= '0;
      shift_q   <= '0;
      first_q   <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= err;

      if (start) begin
        count_q <= '0;
        first_q <= 1'b1;
      end
      if (take) begin
        if (done) begin
          count_q <= '0;
          first_q <= 1'b0;
        end else begin
          shift_q[count_q] <= dio_s;
          count_q          <= count_q + 1'b1;
        end
      end
      if (stb_rise && state_q == RECV) count_q <= '0;

      // The final bit goes straight to the output; it never lands in shift_q.
      if (done && (!out_valid || out_ready)) begin
        out_data  <= {dio_s, shift_q};
        out_first <= first_q;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (done && out_valid && !out_ready) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

  assign busy = (state_q == RECV);

endmodule

// File: tb/tb_spi_rx_deser.sv
// Directed plus randomized bench for spi_rx_deser against a word-level frame model.
module tb_spi_rx_deser;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       spi_stb = 1'b1;
  logic       spi_clk = 1'b1;
  logic       spi_dio = 1'b0;
  logic       out_ready = 1'b1;
  logic       overrun_clr = 1'b0;
  logic [7:0] out_data;
  logic       out_valid, out_first, overrun, frame_err, busy;

  int errors = 0;
  int checks = 0;
  int hp = 2;

  // Each entry is {first, data}.
  logic [8:0] rx_q[$];
  logic [8:0] exp_q[$];
  logic [7:0] frm[$];
  int         err_pulses = 0;
  int         rx_base = 0;
  int         err_base = 0;
  logic [7:0] b;
  int         nbytes;

  always #5 clk = ~clk;

  spi_rx_deser dut (
    .clk(clk), .rst(rst),
    .spi_stb(spi_stb), .spi_clk(spi_clk), .spi_dio(spi_dio),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_first(out_first), .overrun(overrun), .overrun_clr(overrun_clr),
    .frame_err(frame_err), .busy(busy)
  );

  always @(negedge clk) begin
    if (rst && out_valid && out_ready) rx_q.push_back({out_first, out_data});
    if (rst && frame_err) err_pulses++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_out(input logic v);
    spi_clk = 1'b0;
    spi_dio = v;
    cyc(hp);
    spi_clk = 1'b1;
    cyc(hp);
  endtask

  task automatic frame_start();
    spi_stb = 1'b0;
    cyc(hp);
  endtask

  task automatic frame_end();
    spi_stb = 1'b1;
    cyc(hp + 8);
  endtask

  // Sends frm as one frame; when model is set, every byte is expected in order.
  task automatic send_frame(input bit model);
    frame_start();
    foreach (frm[i]) begin
      for (int k = 0; k < 8; k++) bit_out(frm[i][k]);
      if (model) exp_q.push_back({i == 0, frm[i]});
      if (i == 0) check("busy_in_frame", busy, 1);
    end
    frame_end();
  endtask

  task automatic compare(input string tag);
    int n;
    n = rx_q.size() - rx_base;
    check($sformatf("%s.count", tag), n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n; i++)
      check($sformatf("%s.word%0d", tag, i), rx_q[rx_base + i], exp_q[i]);
    exp_q.delete();
    rx_base = rx_q.size();
  endtask

  task automatic check_ferr(input string tag, input int exp);
    check($sformatf("%s.frame_err", tag), err_pulses - err_base, exp);
    err_base = err_pulses;
  endtask

  initial begin
    rst = 1'b0;
    cyc(3);
    check("rst.out_data", out_data, 0);
    check("rst.out_valid", out_valid, 0);
    check("rst.out_first", out_first, 0);
    check("rst.overrun", overrun, 0);
    check("rst.frame_err", frame_err, 0);
    check("rst.busy", busy, 0);
    rst = 1'b1;
    cyc(6);

    // Loopback: walking one across a single frame.
    frm.delete();
    for (int i = 0; i < 8; i++) frm.push_back(8'(1 << i));
    send_frame(1);
    check("loop.busy_idle", busy, 0);
    compare("loop");
    check("loop.overrun", overrun, 0);
    check_ferr("loop", 0);

    // Two frames: first marker must re-arm per frame.
    frm = {8'h40};
    send_frame(1);
    frm = {8'hC0, 8'h55};
    send_frame(1);
    compare("two");
    check_ferr("two", 0);

    // Backpressure: second word is dropped and flagged.
    out_ready = 1'b0;
    frm = {8'hA5, 8'h3C};
    send_frame(0);
    check("bp.valid", out_valid, 1);
    check("bp.data", out_data, 8'hA5);
    check("bp.first", out_first, 1);
    check("bp.overrun", overrun, 1);
    check("bp.none_taken", rx_q.size() - rx_base, 0);
    out_ready = 1'b1;
    cyc(4);
    exp_q.push_back({1'b1, 8'hA5});
    compare("bp");
    check("bp.valid_after", out_valid, 0);
    check("bp.overrun_held", overrun, 1);
    overrun_clr = 1'b1;
    cyc(1);
    overrun_clr = 1'b0;
    cyc(1);
    check("bp.overrun_clr", overrun, 0);
    check_ferr("bp", 0);

    // Partial word: five bits then strobe release.
    b = 8'($urandom);
    frame_start();
    for (int k = 0; k < 5; k++) bit_out(b[k]);
    frame_end();
    check_ferr("partial", 1);
    compare("partial");
    frm = {8'h7E};
    send_frame(1);
    compare("after_partial");
    check_ferr("after_partial", 0);

    // Reset in the middle of a frame; the tail must be ignored.
    b = 8'($urandom);
    frame_start();
    for (int k = 0; k < 3; k++) bit_out(b[k]);
    rst = 1'b0;
    cyc(2);
    rst = 1'b1;
    for (int k = 3; k < 8; k++) begin
      bit_out(b[k]);
      if (k == 5) check("rstmid.busy", busy, 0);
    end
    check("rstmid.valid", out_valid, 0);
    frame_end();
    compare("rstmid");
    check_ferr("rstmid", 0);
    frm = {8'h99};
    send_frame(1);
    compare("after_rstmid");

    // Last clock rise and strobe rise on the same clk edge.
    b = 8'($urandom);
    frame_start();
    for (int k = 0; k < 7; k++) bit_out(b[k]);
    spi_clk = 1'b0;
    spi_dio = b[7];
    cyc(hp);
    spi_clk = 1'b1;
    spi_stb = 1'b1;
    cyc(hp + 8);
    exp_q.push_back({1'b1, b});
    compare("simul");
    check_ferr("simul", 0);

    // Random frames at random legal link speeds.
    for (int f = 0; f < 6; f++) begin
      hp = $urandom_range(2, 4);
      nbytes = $urandom_range(1, 4);
      frm.delete();
      for (int i = 0; i < nbytes; i++) frm.push_back(8'($urandom));
      send_frame(1);
    end
    hp = 2;
    compare("rand");
    check_ferr("rand", 0);
    check("rand.overrun", overrun, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
